fp16_mul_unit: RTL and testbench

Pipelined IEEE-754 binary16 (half-precision) multiplier with a registered output. It takes two 16-bit operands each cycle and returns the rounded product one clock edge later. It is the multiply stage of the datapath's half-precision arithmetic and accepts a new operand pair on every cycle.

---
 rtl/fp16_mul_unit.sv | 48 ++++
 tb/tb_fp16_mul_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/fp16_mul_unit.sv
// fp16_mul_unit: binary16 multiplier with RNE rounding, flush-to-zero and a registered result
module fp16_mul_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result
);
  logic [15:0] result_d, result_q, norm_res;
  logic [21:0] p;
  logic [11:0] m;
  logic [9:0] frac;
  logic signed [7:0] e, ef;
  logic sign, hi, g, r, s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  // combinational product: normalise, round to nearest even, then let special operands override
  always_comb begin
    sign = a[15] ^ b[15];
    a_nan = (&a[14:10]) & (|a[9:0]);
    b_nan = (&b[14:10]) & (|b[9:0]);
    a_inf = (&a[14:10]) & ~(|a[9:0]);
    b_inf = (&b[14:10]) & ~(|b[9:0]);
    a_zero = ~(|a[14:10]);
    b_zero = ~(|b[14:10]);
    p = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
    hi = p[21];
    e = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15 + $signed({7'b0, hi});
    frac = hi ? p[20:11] : p[19:10];
    g = hi ? p[10] : p[9];
    r = hi ? p[9] : p[8];
    s = hi ? |p[8:0] : |p[7:0];
    m = {2'b01, frac} + {11'b0, g & (r | s | frac[0])};
    ef = e + $signed({7'b0, m[11]});
    norm_res = ef >= 8'sd31 ? {sign, 5'h1f, 10'h0} :
               ef <= 8'sd0  ? {sign, 15'h0} :
                              {sign, ef[4:0], m[9:0]};
    result_d = (a_nan | b_nan)                    ? 16'h7e00 :
               ((a_zero & b_inf) | (a_inf & b_zero)) ? 16'h7e00 :
               (a_inf | b_inf)                    ? {sign, 5'h1f, 10'h0} :
               (a_zero | b_zero)                  ? {sign, 15'h0} :
                                                    norm_res;
  end
  // output register, cleared asynchronously so reset discards any in-flight product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) result_q <= 16'h0000;
    else result_q <= result_d;
  end
  assign result = result_q;
endmodule

// File: tb/tb_fp16_mul_unit.sv
// tb_fp16_mul_unit: directed and randomized checks of fp16_mul_unit against a real-arithmetic model
module tb_fp16_mul_unit;
  logic clk, rst_n;
  logic [15:0] a, b, result;
  int checks = 0;
  int errors = 0;

  fp16_mul_unit dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .result(result));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real pow2(input int k);
    real v = 1.0;
    for (int i = 0; i < (k < 0 ? -k : k); i++) v = (k < 0) ? v / 2.0 : v * 2.0;
    return v;
  endfunction

  // reference: exact product in double precision, then RNE to 11 significant bits, FTZ
  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    logic sg;
    int ex, ey, e, fl, be;
    real v, q, d;
    sg = x[15] ^ y[15];
    ex = int'(x[14:10]);
    ey = int'(y[14:10]);
    if ((ex == 31 && x[9:0] != 0) || (ey == 31 && y[9:0] != 0)) return 16'h7e00;
    if ((ex == 0 && ey == 31) || (ex == 31 && ey == 0)) return 16'h7e00;
    if (ex == 31 || ey == 31) return {sg, 15'h7c00};
    if (ex == 0 || ey == 0) return {sg, 15'h0};
    v = real'(1024 + int'(x[9:0])) * pow2(ex - 25) * real'(1024 + int'(y[9:0])) * pow2(ey - 25);
    e = 0;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    q = v * 1024.0;
    fl = $rtoi(q);
    d = q - real'(fl);
    if (d > 0.5 || (d == 0.5 && (fl % 2) == 1)) fl++;
    if (fl == 2048) begin fl = 1024; e++; end
    be = e + 15;
    if (be >= 31) return {sg, 15'h7c00};
    if (be <= 0) return {sg, 15'h0};
    return {sg, 5'(be), 10'(fl)};
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    checks++;
    assert (result === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, result, exp);
    end
  endtask

  task automatic step(input logic [15:0] x, input logic [15:0] y, input logic [15:0] exp, input string tag);
    @(negedge clk);
    a = x;
    b = y;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    logic [15:0] x, y;
    rst_n = 1'b0;
    a = 16'h3c00;
    b = 16'h4000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      @(posedge clk);
      #1;
      check("reset_hold", 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h3c00, 16'h4000, 16'h4000, "first_after_reset");
    step(16'h553f, 16'hd304, 16'hec9a, "round_up");
    step(16'h49ba, 16'h3ccb, 16'h4add, "mixed_1");
    step(16'hd4bf, 16'hd317, 16'h6c35, "mixed_2");
    step(16'h7bff, 16'h7bff, 16'h7c00, "overflow");
    step(16'h0400, 16'h0400, 16'h0000, "underflow_pos");
    step(16'h8400, 16'h0400, 16'h8000, "underflow_neg");
    step(16'h0000, 16'h7c00, 16'h7e00, "zero_x_inf");
    step(16'h7e01, 16'h3c00, 16'h7e00, "nan_in");
    step(16'hfc00, 16'h4000, 16'hfc00, "neg_inf");
    step(16'h0001, 16'h4000, 16'h0000, "subnormal_in");
    step(16'h7c00, 16'hfc00, 16'hfc00, "inf_x_inf");
    step(16'h8000, 16'h3c00, 16'h8000, "neg_zero");
    // mid-stream asynchronous reset discards the held product immediately
    step(16'h4000, 16'h4000, 16'h4400, "pre_reset");
    @(negedge clk);
    a = 16'h4200;
    b = 16'h4200;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 16'h0000);
    @(posedge clk);
    #1;
    check("reset_discard", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h4200, 16'h4200, 16'h4880, "post_reset");
    for (int i = 0; i < 60; i++) begin
      x = {1'($urandom), 5'($urandom_range(22, 8)), 10'($urandom)};
      y = {1'($urandom), 5'($urandom_range(22, 8)), 10'($urandom)};
      step(x, y, ref_mul(x, y), "random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
